// File: rtl/subtrator_pkg.sv
// Shared definitions for the serial subtractor: FSM state encoding and default operand width.
package subtrator_pkg;

  localparam int unsigned N_PADRAO = 8;

  typedef enum logic [1:0] {
    OCIOSO  = 2'b00,
    CALCULA = 2'b01,
    FIM     = 2'b10
  } estado_e;

endpackage

// File: rtl/subtrator_serial8bits_if.sv
// Start/done handshake and operand/result bus of the serial subtractor.
interface subtrator_serial8bits_if
  import subtrator_pkg::*;
#(
  parameter int unsigned N = N_PADRAO
) ();

  logic         inicio;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [N:0]   D;
  logic         ocupado;
  logic         valido;

  modport master (
    output inicio,
    output A,
    output B,
    input  D,
    input  ocupado,
    input  valido
  );

  modport slave (
    input  inicio,
    input  A,
    input  B,
    output D,
    output ocupado,
    output valido
  );

endinterface

// File: rtl/subtrator_completo.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
module subtrator_completo (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/subtrator_serial8bits.sv
// Bit-serial N-bit subtractor: D = A - B, LSB first, one bit per clock, N+1-bit result.
module subtrator_serial8bits
  import subtrator_pkg::*;
#(
  parameter int unsigned N = N_PADRAO
) (
  input  logic                    clk,
  input  logic                    rst_n,
  subtrator_serial8bits_if.slave  bus
);

  localparam int unsigned     CntW    = $clog2(N);
  localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

  estado_e         estado_q, estado_d;
  logic [N-1:0]    ra_q, ra_d;
  logic [N-1:0]    rb_q, rb_d;
  logic [N-1:0]    res_q, res_d;
  logic            borrow_q, borrow_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N:0]      d_q, d_d;
  logic            ocupado_q, ocupado_d;
  logic            valido_q, valido_d;
  logic            dif_bit;
  logic            borrow_out;

  subtrator_completo u_subtrator_completo (
    .a    (ra_q[0]),
    .b    (rb_q[0]),
    .bin  (borrow_q),
    .d    (dif_bit),
    .bout (borrow_out)
  );

  always_comb begin
    estado_d = estado_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    d_d      = d_q;
    valido_d = 1'b0;

    case (estado_q)
      OCIOSO: begin
        if (bus.inicio) begin
          ra_d     = bus.A;
          rb_d     = bus.B;
          borrow_d = 1'b0;
          cnt_d    = '0;
          estado_d = CALCULA;
        end
      end
      CALCULA: begin
        ra_d     = ra_q >> 1;
        rb_d     = rb_q >> 1;
        res_d    = {dif_bit, res_q[N-1:1]};
        borrow_d = borrow_out;
        if (cnt_q == CntLast) begin
          // Last bit: publish the full result on this edge so valido and D align in FIM.
          d_d      = {borrow_out, dif_bit, res_q[N-1:1]};
          valido_d = 1'b1;
          estado_d = FIM;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIM: begin
        estado_d = OCIOSO;
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase

    ocupado_d = (estado_d != OCIOSO);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_q  <= OCIOSO;
      ra_q      <= '0;
      rb_q      <= '0;
      res_q     <= '0;
      borrow_q  <= 1'b0;
      cnt_q     <= '0;
      d_q       <= '0;
      ocupado_q <= 1'b0;
      valido_q  <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      res_q     <= res_d;
      borrow_q  <= borrow_d;
      cnt_q     <= cnt_d;
      d_q       <= d_d;
      ocupado_q <= ocupado_d;
      valido_q  <= valido_d;
    end
  end

  assign bus.D       = d_q;
  assign bus.ocupado = ocupado_q;
  assign bus.valido  = valido_q;

endmodule

// File: tb/tb_subtrator_serial8bits.sv
// Self-checking bench for the serial subtractor: vector table, corner sequences, random soak.
module tb_subtrator_serial8bits;

  localparam int unsigned N = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  subtrator_serial8bits_if #(.N(N)) bus ();

  subtrator_serial8bits #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] d;
  } vec_t;

  vec_t vecs[7];

  // Reference: plain integer subtraction reduced modulo 2^(N+1).
  function automatic logic [8:0] ref_sub(input int a, input int b);
    int r;
    r = a - b + 512;
    return r[8:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One isolated operation; samples cycles t+1 .. t+12 on the falling edge.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [8:0] exp,
                        input string tag);
    int v_at, v_cnt, o_cnt;
    logic [8:0] d_at_v;
    v_at = 0; v_cnt = 0; o_cnt = 0; d_at_v = '0;
    @(negedge clk);
    bus.inicio = 1'b1; bus.A = a; bus.B = b;
    @(posedge clk);
    #1;
    bus.inicio = 1'b0; bus.A = 8'($urandom); bus.B = 8'($urandom);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus.ocupado) o_cnt++;
      if (bus.valido) begin
        v_cnt++;
        if (v_at == 0) begin
          v_at   = k;
          d_at_v = bus.D;
        end
      end
    end
    chk({tag, " D"}, d_at_v, exp);
    chk({tag, " model"}, d_at_v, ref_sub(a, b));
    chk({tag, " latency"}, v_at, 9);
    chk({tag, " valido count"}, v_cnt, 1);
    chk({tag, " ocupado cycles"}, o_cnt, 9);
    chk({tag, " D held"}, bus.D, exp);
  endtask

  initial begin
    logic [8:0] exp_q[$];
    int acc_cyc_q[$];
    int last_v;
    int v_seen[$];
    logic [8:0] d_seen[$];
    int o10, o11;

    checks = 0; errors = 0;
    vecs[0] = '{8'd100, 8'd37,  9'h03F};
    vecs[1] = '{8'd37,  8'd100, 9'h1C1};
    vecs[2] = '{8'd0,   8'd0,   9'h000};
    vecs[3] = '{8'd255, 8'd0,   9'h0FF};
    vecs[4] = '{8'd0,   8'd255, 9'h101};
    vecs[5] = '{8'd255, 8'd255, 9'h000};
    vecs[6] = '{8'd200, 8'd1,   9'h0C7};

    rst_n = 1'b0; bus.inicio = 1'b0; bus.A = '0; bus.B = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset D", bus.D, 0);
    chk("reset ocupado", bus.ocupado, 0);
    chk("reset valido", bus.valido, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].d, $sformatf("vec%0d", i));

    // inicio held high, operands changed during CALCULA, second accept at t+10.
    @(negedge clk);
    bus.inicio = 1'b1; bus.A = 8'd100; bus.B = 8'd37;
    @(posedge clk);
    o10 = -1; o11 = -1;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (k == 1) begin bus.A = 8'd5; bus.B = 8'd9; end
      if (k == 10) o10 = int'(bus.ocupado);
      if (k == 11) begin o11 = int'(bus.ocupado); bus.inicio = 1'b0; end
      if (bus.valido) begin v_seen.push_back(k); d_seen.push_back(bus.D); end
    end
    chk("b2b valido count", v_seen.size(), 2);
    if (v_seen.size() == 2) begin
      chk("b2b first latency", v_seen[0], 9);
      chk("b2b first D", d_seen[0], 9'h03F);
      chk("b2b second latency", v_seen[1], 19);
      chk("b2b second D", d_seen[1], 9'h1FC);
    end
    chk("b2b idle gap", o10, 0);
    chk("b2b reaccept", o11, 1);

    // Reset during CALCULA cycle 4 aborts the operation.
    @(negedge clk);
    bus.inicio = 1'b1; bus.A = 8'd100; bus.B = 8'd37;
    @(posedge clk);
    #1 bus.inicio = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 4) rst_n = 1'b0;
      if (k == 5) begin
        rst_n = 1'b1;
        chk("abort ocupado", bus.ocupado, 0);
        chk("abort D", bus.D, 0);
      end
      if (k >= 4) chk($sformatf("abort no valido k%0d", k), bus.valido, 0);
    end
    run_op(8'd200, 8'd1, 9'h0C7, "post-abort");

    // Random soak with random inicio duty; accepts inferred from ocupado before the edge.
    last_v = -100;
    for (int cyc = 0; cyc < 30000; cyc++) begin
      logic ini;
      logic [7:0] a, b;
      @(negedge clk);
      if (bus.valido) begin
        if (exp_q.size() == 0) begin
          chk("soak valido without accept", 1, 0);
        end else begin
          chk("soak D", bus.D, exp_q.pop_front());
          chk("soak latency", cyc - acc_cyc_q.pop_front(), 9);
        end
        if (cyc - last_v < 10) chk("soak valido spacing", cyc - last_v, 10);
        last_v = cyc;
      end
      ini = ($urandom_range(3) != 0);
      a = 8'($urandom);
      b = 8'($urandom);
      bus.inicio = ini; bus.A = a; bus.B = b;
      if (ini && !bus.ocupado) begin
        exp_q.push_back(ref_sub(int'(a), int'(b)));
        acc_cyc_q.push_back(cyc);
      end
    end
    bus.inicio = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (bus.valido && exp_q.size() > 0) chk("soak drain D", bus.D, exp_q.pop_front());
    end
    chk("soak queue empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
